// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared defaults for pipeline-stage registers.
package pipe_reg_pkg;
    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_CNT_W_DEF = 16;
endpackage

// File: rtl/pipe_reg_entry.sv
// pipe_reg_entry: data register plus valid bit with load, clear and async active-low reset.
module pipe_reg_entry #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // clear only drops valid; data is don't-care while invalid
    always_comb begin
        data_d  = ld ? d : data_q;
        valid_d = clr ? 1'b0 : ld ? 1'b1 : valid_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q = data_q;
    assign v = valid_q;
endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: valid/ready pipeline-stage register with flush and saturating stall counter.
// Defining PIPE_REG_SKID_EN adds a skid entry so in_ready no longer depends on out_ready.
module pipe_reg import pipe_reg_pkg::*; #(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int CNT_W = PIPE_CNT_W_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_count,
    output logic [CNT_W-1:0] stall_count
);
    logic             in_xfer, out_xfer;
    logic             m_ld, m_clr;
    logic [WIDTH-1:0] m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef PIPE_REG_SKID_EN
    logic             s_ld, s_clr, s_valid;
    logic [WIDTH-1:0] s_data;

    assign in_ready = flush || !s_valid;

    // a parked skid word always drains ahead of new input
    always_comb begin
        m_d   = s_valid ? s_data : in_data;
        m_ld  = !flush && (!out_valid || out_ready) && (s_valid || in_xfer);
        m_clr = flush || (out_xfer && !s_valid && !in_xfer);
        s_ld  = !flush && in_xfer && out_valid && !out_ready;
        s_clr = flush || (s_valid && out_xfer);
    end

    pipe_reg_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .ld      (s_ld),
        .clr     (s_clr),
        .d       (in_data),
        .q       (s_data),
        .v       (s_valid)
    );
`else
    assign in_ready = flush || !out_valid || out_ready;

    always_comb begin
        m_d   = in_data;
        m_ld  = in_xfer && !flush;
        m_clr = flush || (out_xfer && !in_xfer);
    end
`endif

    pipe_reg_entry #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clock   (clock),
        .reset_n (reset_n),
        .ld      (m_ld),
        .clr     (m_clr),
        .d       (m_d),
        .q       (out_data),
        .v       (out_valid)
    );

    always_comb begin
        cnt_d = clr_count ? '0
              : (out_valid && !out_ready && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1)
              : cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed checks of reset, streaming, stall, flush, counter saturation and async reset.
module tb_pipe_reg;
    logic        clock = 1'b0;
    logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready, clr_count;
    logic [31:0] in_data, out_data;
    logic [2:0]  stall_count;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    pipe_reg #(.WIDTH(32), .CNT_W(3), .RESET_VAL(32'h0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clr_count   (clr_count),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
        out_ready = 1'b1; flush = 1'b0; clr_count = 1'b0;
        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_cnt", {29'b0, stall_count}, 32'd0);
        #10 reset_n = 1'b1;
        step();
        chk("rel_data", out_data, 32'hDEADBEEF);
        chk("rel_valid", {31'b0, out_valid}, 32'd1);

        in_data = 32'h0000BABE; step();
        chk("str0", out_data, 32'h0000BABE);
        in_data = 32'h1111BABE; step();
        chk("str1", out_data, 32'h1111BABE);
        chk("str1_v", {31'b0, out_valid}, 32'd1);
        in_data = 32'h2222BABE; step();
        chk("str2", out_data, 32'h2222BABE);
        chk("str2_v", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0; step();
        chk("drain_v", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1; in_data = 32'hCAFEF00D; out_ready = 1'b0; step();
        chk("stl_load", out_data, 32'hCAFEF00D);
        chk("stl_cnt0", {29'b0, stall_count}, 32'd0);
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("stl_data", out_data, 32'hCAFEF00D);
`ifdef PIPE_REG_SKID_EN
            chk("stl_rdy", {31'b0, in_ready}, 32'd1);
`else
            chk("stl_rdy", {31'b0, in_ready}, 32'd0);
`endif
        end
        chk("stl_cnt5", {29'b0, stall_count}, 32'd5);

        for (int i = 0; i < 5; i++) step();
        chk("sat_cnt", {29'b0, stall_count}, 32'd7);
        chk("sat_data", out_data, 32'hCAFEF00D);
        clr_count = 1'b1; step();
        chk("clr_cnt", {29'b0, stall_count}, 32'd0);
        clr_count = 1'b0; step();
        chk("post_clr", {29'b0, stall_count}, 32'd1);

        flush = 1'b1; in_valid = 1'b1; in_data = 32'h12345678; #1;
        chk("fl_rdy", {31'b0, in_ready}, 32'd1);
        step();
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_cnt", {29'b0, stall_count}, 32'd2);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk("fl_after", {31'b0, out_valid}, 32'd0);

        in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b0; step();
        chk("ar_load", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0; step();
        chk("ar_cnt", {29'b0, stall_count}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_cnt0", {29'b0, stall_count}, 32'd0);
        chk("ar_data", out_data, 32'h0);
        chk("ar_rdy", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
